// File: rtl/can_frame_tracker.sv
// can_frame_tracker: follows a received CAN 2.0A/2.0B frame on the destuffed,
// sampled bit stream. Captures IDE/RTR/DLC, derives the data byte count and the
// total frame length (including intermission), and flags the data/CRC fields.
module can_frame_tracker #(
  parameter int CNT_W     = 8,
  parameter int IFS_BITS  = 3,
  parameter int MAX_BYTES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dvalid,
  input  logic             din,
  input  logic             sof,
  input  logic             error,
  input  logic             overload,
  output logic             sample_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic             ide,
  output logic             rtr,
  output logic [3:0]       dlc,
  output logic [3:0]       data_bytes,
  output logic [CNT_W-1:0] frame_len,
  output logic             len_valid,
  output logic             in_data,
  output logic             in_crc,
  output logic             frame_done,
  output logic             frame_abort
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_EXT_ARB = 3'd2,
    ST_CTRL    = 3'd3,
    ST_DATA    = 3'd4,
    ST_CRC     = 3'd5,
    ST_TAIL    = 3'd6
  } state_t;

  // Fixed bit positions within the frame (SOF = 0)
  localparam logic [CNT_W-1:0] ONE            = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDX_RTR_STD    = CNT_W'(12);
  localparam logic [CNT_W-1:0] IDX_IDE        = CNT_W'(13);
  localparam logic [CNT_W-1:0] IDX_RTR_EXT    = CNT_W'(32);
  localparam logic [CNT_W-1:0] DLC_LAST_STD   = CNT_W'(18);
  localparam logic [CNT_W-1:0] DLC_LAST_EXT   = CNT_W'(38);
  localparam logic [CNT_W-1:0] DATA_START_STD = CNT_W'(19);
  localparam logic [CNT_W-1:0] DATA_START_EXT = CNT_W'(39);
  localparam logic [CNT_W-1:0] CRC_LAST_OFS   = CNT_W'(14);
  localparam logic [CNT_W-1:0] LEN_BASE_STD   = CNT_W'(44 + IFS_BITS);
  localparam logic [CNT_W-1:0] LEN_BASE_EXT   = CNT_W'(64 + IFS_BITS);
  localparam logic [3:0]       MAX_B          = 4'(MAX_BYTES);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] bit_idx_r, frame_len_r, crc_start_r;
  logic             ide_r, rtr_r, len_valid_r, done_r, abort_r;
  logic [3:0]       dlc_r, data_bytes_r;
  logic [2:0]       dlc_sh_r;

  logic             kill_s, start_s;
  logic             dlc_last_s, data_last_s, crc_last_s, tail_last_s;
  logic [3:0]       dlc_full_s, nbytes_s;
  logic [CNT_W-1:0] dlc_end_idx_s, len_s, crc_start_s, data_bits_s;

  // Frame-level events, byte clamp, length arithmetic and field boundaries
  always_comb begin
    kill_s     = (error | overload) & (state_r != ST_IDLE);
    start_s    = sof & ~error & ~overload & (state_r == ST_IDLE);
    dlc_full_s = {dlc_sh_r, din};
    if (rtr_r) begin
      nbytes_s = 4'd0;
    end else if (dlc_full_s > MAX_B) begin
      nbytes_s = MAX_B;
    end else begin
      nbytes_s = dlc_full_s;
    end
    data_bits_s = CNT_W'({nbytes_s, 3'b000});
    if (ide_r) begin
      dlc_end_idx_s = DLC_LAST_EXT;
      len_s         = LEN_BASE_EXT + data_bits_s;
      crc_start_s   = DATA_START_EXT + data_bits_s;
    end else begin
      dlc_end_idx_s = DLC_LAST_STD;
      len_s         = LEN_BASE_STD + data_bits_s;
      crc_start_s   = DATA_START_STD + data_bits_s;
    end
    dlc_last_s  = dvalid & (state_r == ST_CTRL) & (bit_idx_r == dlc_end_idx_s);
    data_last_s = dvalid & (state_r == ST_DATA) & (bit_idx_r == crc_start_r - ONE);
    crc_last_s  = dvalid & (state_r == ST_CRC)  & (bit_idx_r == crc_start_r + CRC_LAST_OFS);
    tail_last_s = dvalid & (state_r == ST_TAIL) & (bit_idx_r == frame_len_r - ONE);
  end

  // Next-state logic; error/overload override any bit-driven transition
  always_comb begin
    state_s = state_r;
    if (kill_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) state_s = ST_ARB;
          else         state_s = ST_IDLE;
        end
        ST_ARB: begin
          if (dvalid && (bit_idx_r == IDX_IDE)) begin
            if (din) state_s = ST_EXT_ARB;
            else     state_s = ST_CTRL;
          end else begin
            state_s = ST_ARB;
          end
        end
        ST_EXT_ARB: begin
          if (dvalid && (bit_idx_r == IDX_RTR_EXT)) state_s = ST_CTRL;
          else                                      state_s = ST_EXT_ARB;
        end
        ST_CTRL: begin
          if (dlc_last_s) begin
            if (nbytes_s != 4'd0) state_s = ST_DATA;
            else                  state_s = ST_CRC;
          end else begin
            state_s = ST_CTRL;
          end
        end
        ST_DATA: begin
          if (data_last_s) state_s = ST_CRC;
          else             state_s = ST_DATA;
        end
        ST_CRC: begin
          if (crc_last_s) state_s = ST_TAIL;
          else            state_s = ST_CRC;
        end
        ST_TAIL: begin
          if (tail_last_s) state_s = ST_IDLE;
          else             state_s = ST_TAIL;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Bit counter, captured header fields, length and completion/abort pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_r    <= '0;
      frame_len_r  <= '0;
      crc_start_r  <= '0;
      ide_r        <= 1'b0;
      rtr_r        <= 1'b0;
      dlc_r        <= 4'd0;
      data_bytes_r <= 4'd0;
      dlc_sh_r     <= 3'd0;
      len_valid_r  <= 1'b0;
      done_r       <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      if (kill_s) begin
        bit_idx_r   <= '0;
        len_valid_r <= 1'b0;
        abort_r     <= 1'b1;
      end else if (start_s) begin
        // New frame: previous header fields are discarded here
        bit_idx_r    <= ONE;
        frame_len_r  <= '0;
        crc_start_r  <= '0;
        ide_r        <= 1'b0;
        rtr_r        <= 1'b0;
        dlc_r        <= 4'd0;
        data_bytes_r <= 4'd0;
        dlc_sh_r     <= 3'd0;
        len_valid_r  <= 1'b0;
      end else if (dvalid && (state_r != ST_IDLE)) begin
        if (tail_last_s) begin
          bit_idx_r   <= '0;
          len_valid_r <= 1'b0;
          done_r      <= 1'b1;
        end else begin
          bit_idx_r <= bit_idx_r + ONE;
        end
        if ((state_r == ST_ARB) && (bit_idx_r == IDX_RTR_STD)) rtr_r <= din;
        if ((state_r == ST_ARB) && (bit_idx_r == IDX_IDE))     ide_r <= din;
        if ((state_r == ST_EXT_ARB) && (bit_idx_r == IDX_RTR_EXT)) rtr_r <= din;
        if (state_r == ST_CTRL) begin
          // r0/r1 also pass through the shifter; only the last four bits form the DLC
          dlc_sh_r <= {dlc_sh_r[1:0], din};
          if (dlc_last_s) begin
            dlc_r        <= dlc_full_s;
            data_bytes_r <= nbytes_s;
            frame_len_r  <= len_s;
            crc_start_r  <= crc_start_s;
            len_valid_r  <= 1'b1;
          end
        end
      end
    end
  end

  assign sample_en   = (state_r != ST_IDLE);
  assign bit_idx     = bit_idx_r;
  assign ide         = ide_r;
  assign rtr         = rtr_r;
  assign dlc         = dlc_r;
  assign data_bytes  = data_bytes_r;
  assign frame_len   = frame_len_r;
  assign len_valid   = len_valid_r;
  assign in_data     = (state_r == ST_DATA);
  assign in_crc      = (state_r == ST_CRC);
  assign frame_done  = done_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_can_frame_tracker.sv
// Bench for can_frame_tracker: directed frames; expected completions and
// point probes are queued by the stimulus and compared by a falling-edge monitor.
module tb_can_frame_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dvalid = 1'b0, din = 1'b1, sof = 1'b0, error = 1'b0, overload = 1'b0;
  logic       sample_en, ide, rtr, len_valid, in_data, in_crc, frame_done, frame_abort;
  logic [7:0] bit_idx, frame_len;
  logic [3:0] dlc, data_bytes;

  can_frame_tracker #(.CNT_W(8), .IFS_BITS(3), .MAX_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .dvalid(dvalid), .din(din), .sof(sof),
    .error(error), .overload(overload), .sample_en(sample_en), .bit_idx(bit_idx),
    .ide(ide), .rtr(rtr), .dlc(dlc), .data_bytes(data_bytes), .frame_len(frame_len),
    .len_valid(len_valid), .in_data(in_data), .in_crc(in_crc),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_abort; bit ide; bit rtr;
    int dlc; int db; int len; int dfirst; int dcnt; int cfirst; int ccnt;
  } exp_t;

  typedef struct { int sel; int tag; longint val; } probe_t;

  localparam int SEL_IDX = 0, SEL_SE = 1, SEL_ALL = 2;

  exp_t   exp_q[$];
  probe_t probe_q[$];
  exp_t   e;
  probe_t p;
  int     n_chk = 0, n_pass = 0;
  int     bits_seen = 0, dfirst = 0, dcnt = 0, cfirst = 0, ccnt = 0;
  bit     lv_seen = 1'b0;
  bit     drain_req = 1'b0, drain_chk = 1'b0;
  logic [127:0] f;

  task automatic chk(input string name, input longint act, input longint want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  function automatic longint sig_val(input int sel);
    case (sel)
      SEL_IDX: return longint'(bit_idx);
      SEL_SE:  return longint'(sample_en);
      default: return longint'({sample_en, bit_idx, ide, rtr, dlc, data_bytes, frame_len,
                                len_valid, in_data, in_crc, frame_done, frame_abort});
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_IDX: return "bit_idx";
      SEL_SE:  return "sample_en";
      default: return "all_outputs";
    endcase
  endfunction

  // Monitor: probes, completion/abort scoreboard and per-frame field statistics
  always @(negedge clk) begin
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      chk($sformatf("%s@%0d", sel_name(p.sel), p.tag), sig_val(p.sel), p.val);
    end
    if (frame_done || frame_abort) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_is_abort", longint'(frame_abort), longint'(e.is_abort));
        chk("pulse_is_done", longint'(frame_done), longint'(!e.is_abort));
        chk("post_bit_idx", longint'(bit_idx), 0);
        chk("post_sample_en", longint'(sample_en), 0);
        chk("post_len_valid", longint'(len_valid), 0);
        if (!e.is_abort) begin
          chk("ide", longint'(ide), longint'(e.ide));
          chk("rtr", longint'(rtr), longint'(e.rtr));
          chk("dlc", longint'(dlc), e.dlc);
          chk("data_bytes", longint'(data_bytes), e.db);
          chk("frame_len", longint'(frame_len), e.len);
          chk("bits_to_done", bits_seen, e.len);
          chk("data_bits", dcnt, e.dcnt);
          if (e.dcnt != 0) chk("data_first_idx", dfirst, e.dfirst);
          chk("crc_bits", ccnt, e.ccnt);
          chk("crc_first_idx", cfirst, e.cfirst);
          chk("len_valid_seen", longint'(lv_seen), 1);
        end
      end
    end
    if (!sample_en && !(dvalid && sof)) begin
      bits_seen = 0; dcnt = 0; ccnt = 0; dfirst = 0; cfirst = 0; lv_seen = 1'b0;
    end else begin
      if (dvalid) begin
        bits_seen++;
        if (in_data) begin
          if (dcnt == 0) dfirst = int'(bit_idx);
          dcnt++;
        end
        if (in_crc) begin
          if (ccnt == 0) cfirst = int'(bit_idx);
          ccnt++;
        end
      end
      if (len_valid) lv_seen = 1'b1;
    end
    if (drain_req && !drain_chk) begin
      chk("pending_expectations", exp_q.size(), 0);
      drain_chk = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int sel, input int tag, input longint val);
    probe_t q;
    q.sel = sel; q.tag = tag; q.val = val;
    probe_q.push_back(q);
  endtask

  function automatic exp_t mk_exp(input bit ab, input bit i, input bit r, input int d,
                                  input int db, input int len, input int df, input int dc,
                                  input int cf);
    exp_t x;
    x.is_abort = ab; x.ide = i; x.rtr = r; x.dlc = d; x.db = db; x.len = len;
    x.dfirst = df; x.dcnt = dc; x.cfirst = cf; x.ccnt = 15;
    return x;
  endfunction

  function automatic logic [127:0] mk_frame(input bit ext, input bit r, input logic [3:0] d,
                                            input logic [10:0] id);
    logic [127:0] fr;
    fr = 128'h5A3C_96E1_0F0F_33CC_A55A_6996_C3C3_1E1E;
    fr[0] = 1'b0;
    for (int k = 0; k < 11; k++) fr[1+k] = id[10-k];
    if (!ext) begin
      fr[12] = r; fr[13] = 1'b0; fr[14] = 1'b0;
      for (int k = 0; k < 4; k++) fr[15+k] = d[3-k];
    end else begin
      fr[12] = 1'b1; fr[13] = 1'b1; fr[32] = r; fr[33] = 1'b0; fr[34] = 1'b0;
      for (int k = 0; k < 4; k++) fr[35+k] = d[3-k];
    end
    return fr;
  endfunction

  // One bit every two cycles; optional error/overload/extra sof/reset at a bit index
  task automatic send_frame(input logic [127:0] fr, input int nbits, input int err_at,
                            input int ovl_at, input int sof_at, input int rst_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0; #1;
        probe(SEL_ALL, i, 0);
        tick();
        probe(SEL_ALL, i, 0);
        tick();
        rst_n = 1'b1;
        break;
      end
      dvalid = 1'b1; din = fr[i];
      sof = (i == 0) || (i == sof_at);
      error = (i == err_at);
      overload = (i == ovl_at);
      tick();
      dvalid = 1'b0; sof = 1'b0; error = 1'b0; overload = 1'b0;
      if ((i == err_at) || (i == ovl_at)) begin
        probe(SEL_IDX, i, 0);
        probe(SEL_SE, i, 0);
        tick();
        break;
      end
      probe(SEL_IDX, i, (i == nbits - 1) ? 0 : i + 1);
      tick();
    end
    tick();
  endtask

  initial begin
    probe(SEL_ALL, 900, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    probe(SEL_ALL, 901, 0);
    // dvalid without sof in IDLE: no effect
    dvalid = 1'b1; din = 1'b0; tick();
    dvalid = 1'b0; probe(SEL_IDX, 902, 0); probe(SEL_SE, 902, 0); tick();
    // sof with error in IDLE: error wins
    dvalid = 1'b1; din = 1'b0; sof = 1'b1; error = 1'b1; tick();
    dvalid = 1'b0; sof = 1'b0; error = 1'b0;
    probe(SEL_SE, 903, 0); probe(SEL_IDX, 903, 0); tick();
    // overload alone in IDLE: ignored, no pulse
    overload = 1'b1; tick(); overload = 1'b0; tick();

    // 1: std data, ID 0x123, DLC 2
    f = mk_frame(1'b0, 1'b0, 4'd2, 11'h123);
    exp_q.push_back(mk_exp(0, 0, 0, 2, 2, 63, 19, 16, 35));
    send_frame(f, 63, -1, -1, -1, -1);
    // 2: ext remote, DLC 4
    f = mk_frame(1'b1, 1'b1, 4'd4, 11'h5A5);
    exp_q.push_back(mk_exp(0, 1, 1, 4, 0, 67, 0, 0, 39));
    send_frame(f, 67, -1, -1, -1, -1);
    // ext data, DLC 1: SRR=1 must be overwritten by RTR=0
    f = mk_frame(1'b1, 1'b0, 4'd1, 11'h0F0);
    exp_q.push_back(mk_exp(0, 1, 0, 1, 1, 75, 39, 8, 47));
    send_frame(f, 75, -1, -1, -1, -1);
    // 3: std data, DLC 12 clamps to 8 bytes
    f = mk_frame(1'b0, 1'b0, 4'hC, 11'h7FF);
    exp_q.push_back(mk_exp(0, 0, 0, 12, 8, 111, 19, 64, 83));
    send_frame(f, 111, -1, -1, -1, -1);
    // 4: error at idx 25, then a restart of the same frame
    f = mk_frame(1'b0, 1'b0, 4'd2, 11'h123);
    exp_q.push_back(mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0));
    send_frame(f, 63, 25, -1, -1, -1);
    exp_q.push_back(mk_exp(0, 0, 0, 2, 2, 63, 19, 16, 35));
    send_frame(f, 63, -1, -1, -1, -1);
    // 5: sof at idx 20 mid-frame is ignored
    exp_q.push_back(mk_exp(0, 0, 0, 2, 2, 63, 19, 16, 35));
    send_frame(f, 63, -1, -1, 20, -1);
    // overload in the DLC of an ext data frame
    f = mk_frame(1'b1, 1'b0, 4'd3, 11'h2AA);
    exp_q.push_back(mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0));
    send_frame(f, 91, -1, 36, -1, -1);
    // 6: reset at idx 30, then a new frame decodes
    f = mk_frame(1'b0, 1'b0, 4'd2, 11'h123);
    send_frame(f, 63, -1, -1, -1, 30);
    f = mk_frame(1'b0, 1'b0, 4'hC, 11'h321);
    exp_q.push_back(mk_exp(0, 0, 0, 12, 8, 111, 19, 64, 83));
    send_frame(f, 111, -1, -1, -1, -1);

    for (int w = 0; w < 50; w++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    drain_req = 1'b1;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
